// File: rtl/trap_ret_if.sv
// trap_ret_if: idex/csr-side signals of the trap-exit sequencer.
interface trap_ret_if;
  logic        mret;
  logic        trap_in;
  logic        trap_jump;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] pc_idex;
  logic [31:0] pc_n;
  logic        ret_jump;
  logic        ret_busy;
  logic        ret_err;
  modport master (output mret, trap_in, trap_jump, csr_rdata, pc_idex,
                  input  csr_wdata, csr_we, csr_addr, pc_n, ret_jump, ret_busy, ret_err);
  modport slave  (input  mret, trap_in, trap_jump, csr_rdata, pc_idex,
                  output csr_wdata, csr_we, csr_addr, pc_n, ret_jump, ret_busy, ret_err);
endinterface

// File: rtl/trap_ret.sv
// trap_ret: mret sequencer (restore mstatus, fetch mepc, redirect PC).
// Define TRAP_RET_CHECK_EN to reject mret when the trap nesting depth is zero.
module trap_ret #(
  parameter int MEPC_ALIGN = 2,
  parameter int DEPTH_W    = 4
) (
  input logic       clk,
  input logic       rst_n,
  trap_ret_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, WMST = 2'd1, RDPC = 2'd2, JMPC = 2'd3;
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << MEPC_ALIGN) - 32'd1);
  logic [1:0]  state, state_n;
  logic [31:0] mepc_r;
  logic        illegal, acc;
`ifdef TRAP_RET_CHECK_EN
  logic [DEPTH_W-1:0] depth;
  logic               up, dn;
  assign up = bus.trap_jump;
  assign dn = state == JMPC;
  // saturating at all-ones, clamped at zero; up and dn together cancel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) depth <= '0;
    else if (up && !dn && !(&depth)) depth <= depth + 1'b1;
    else if (dn && !up && |depth) depth <= depth - 1'b1;
  assign illegal = depth == '0;
`else
  logic [DEPTH_W-1:0] unused_depth;
  assign unused_depth = {DEPTH_W{bus.trap_jump}};
  assign illegal = 1'b0;
`endif
  assign acc = bus.mret & ~bus.trap_in & ~illegal;
  always_comb
    state_n = state == IDLE ? (acc ? WMST : IDLE) :
              state == WMST ? RDPC :
              state == RDPC ? JMPC : IDLE;
  assign bus.csr_we    = state == WMST;
  assign bus.csr_addr  = state == WMST ? 12'h300 : state == RDPC ? 12'h341 : 12'h000;
  // MIE <- MPIE, MPIE <- 1
  assign bus.csr_wdata = state == WMST ?
                         {bus.csr_rdata[31:8], 1'b1, bus.csr_rdata[6:4], bus.csr_rdata[7], bus.csr_rdata[2:0]} :
                         32'h0;
  assign bus.pc_n      = state == JMPC ? mepc_r : bus.pc_idex;
  assign bus.ret_jump  = state == JMPC;
  assign bus.ret_busy  = state != IDLE || acc;
  assign bus.ret_err   = state == IDLE && bus.mret && !bus.trap_in && illegal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      mepc_r <= '0;
    end else begin
      state <= state_n;
      if (state == RDPC) mepc_r <= bus.csr_rdata & ALIGN_MASK;
    end
endmodule

// File: tb/tb_trap_ret.sv
// tb_trap_ret: table-driven vectors plus reset and depth-check sequences for trap_ret.
module tb_trap_ret;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] mst = '0, mepc = '0;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  trap_ret_if bus0();
  trap_ret_if bus1();
  assign bus0.csr_rdata = bus0.csr_addr == 12'h300 ? mst : bus0.csr_addr == 12'h341 ? mepc : 32'h0;
  assign bus1.mret      = bus0.mret;
  assign bus1.trap_in   = bus0.trap_in;
  assign bus1.trap_jump = bus0.trap_jump;
  assign bus1.pc_idex   = bus0.pc_idex;
  assign bus1.csr_rdata = bus0.csr_rdata;
  trap_ret dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  trap_ret #(.MEPC_ALIGN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  typedef struct {
    logic        mret, trap_in;
    logic [31:0] ms, mp;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd, pc, pc1;
    logic        jump, busy;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_ret(input logic [31:0] ms, input logic [31:0] mp, input logic [31:0] wd, input logic [31:0] pc);
    @(negedge clk);
    bus0.mret = 1'b1; mst = ms; mepc = mp;
    #1 chk("acc_busy", 32'(bus0.ret_busy), 32'd1);
    @(negedge clk); #1;
    chk("seq_we", 32'(bus0.csr_we), 32'd1);
    chk("seq_wd", bus0.csr_wdata, wd);
    @(negedge clk); #1;
    chk("seq_addr", 32'(bus0.csr_addr), 32'h341);
    @(negedge clk); #1;
    chk("seq_jump", 32'(bus0.ret_jump), 32'd1);
    chk("seq_pc", bus0.pc_n, pc);
    bus0.mret = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus0.mret = 0; bus0.trap_in = 0; bus0.trap_jump = 0; bus0.pc_idex = 32'h100;
    //        mret trap ms            mp            we addr    wd            pc            pc1           jmp busy
    tbl.push_back('{0, 0, 32'h0,        32'h0,        0, 12'h0,   32'h0,        32'h100,      32'h100,      0, 0});
    tbl.push_back('{1, 0, 32'h80,       32'h1236,     0, 12'h0,   32'h0,        32'h100,      32'h100,      0, 1});
    tbl.push_back('{1, 0, 32'h80,       32'h1236,     1, 12'h300, 32'h88,       32'h100,      32'h100,      0, 1});
    tbl.push_back('{1, 0, 32'h80,       32'h1236,     0, 12'h341, 32'h0,        32'h100,      32'h100,      0, 1});
    tbl.push_back('{1, 0, 32'h80,       32'h1236,     0, 12'h0,   32'h0,        32'h1234,     32'h1236,     1, 1});
    tbl.push_back('{0, 0, 32'h80,       32'h1236,     0, 12'h0,   32'h0,        32'h100,      32'h100,      0, 0});
    tbl.push_back('{1, 0, 32'h1808,     32'h80000004, 0, 12'h0,   32'h0,        32'h100,      32'h100,      0, 1});
    tbl.push_back('{1, 0, 32'h1808,     32'h80000004, 1, 12'h300, 32'h1880,     32'h100,      32'h100,      0, 1});
    tbl.push_back('{1, 0, 32'h1808,     32'h80000004, 0, 12'h341, 32'h0,        32'h100,      32'h100,      0, 1});
    tbl.push_back('{1, 0, 32'h1808,     32'h80000004, 0, 12'h0,   32'h0,        32'h80000004, 32'h80000004, 1, 1});
    tbl.push_back('{1, 0, 32'h0,        32'hFFFFFFFF, 0, 12'h0,   32'h0,        32'h100,      32'h100,      0, 1});
    tbl.push_back('{0, 0, 32'h0,        32'hFFFFFFFF, 1, 12'h300, 32'h80,       32'h100,      32'h100,      0, 1});
    tbl.push_back('{0, 1, 32'h0,        32'hFFFFFFFF, 0, 12'h341, 32'h0,        32'h100,      32'h100,      0, 1});
    tbl.push_back('{0, 1, 32'h0,        32'hFFFFFFFF, 0, 12'h0,   32'h0,        32'hFFFFFFFC, 32'hFFFFFFFE, 1, 1});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1, 1, 32'hFFFFFF77, 32'h2003,   0, 12'h0,   32'h0,        32'h100,      32'h100,      0, 0});
    tbl.push_back('{1, 0, 32'hFFFFFF77, 32'h2003,     0, 12'h0,   32'h0,        32'h100,      32'h100,      0, 1});
    tbl.push_back('{1, 0, 32'hFFFFFF77, 32'h2003,     1, 12'h300, 32'hFFFFFFF7, 32'h100,      32'h100,      0, 1});
    tbl.push_back('{1, 0, 32'hFFFFFF77, 32'h2003,     0, 12'h341, 32'h0,        32'h100,      32'h100,      0, 1});
    tbl.push_back('{0, 0, 32'hFFFFFF77, 32'h2003,     0, 12'h0,   32'h0,        32'h2000,     32'h2002,     1, 1});
    tbl.push_back('{0, 0, 32'hFFFFFF77, 32'h2003,     0, 12'h0,   32'h0,        32'h100,      32'h100,      0, 0});
    #1;
    chk("rst_busy", 32'(bus0.ret_busy), 32'd0);
    chk("rst_pc", bus0.pc_n, 32'h100);
    chk("rst_jump", 32'(bus0.ret_jump), 32'd0);
    chk("rst_err", 32'(bus0.ret_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef TRAP_RET_CHECK_EN
    bus0.trap_jump = 1'b1;
    repeat (5) @(negedge clk);
    bus0.trap_jump = 1'b0;
`endif
    foreach (tbl[i]) begin
      @(negedge clk);
      bus0.mret = tbl[i].mret; bus0.trap_in = tbl[i].trap_in; mst = tbl[i].ms; mepc = tbl[i].mp;
      #1;
      chk($sformatf("v%0d_we", i), 32'(bus0.csr_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_addr", i), 32'(bus0.csr_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_wd", i), bus0.csr_wdata, tbl[i].wd);
      chk($sformatf("v%0d_pc", i), bus0.pc_n, tbl[i].pc);
      chk($sformatf("v%0d_pc1", i), bus1.pc_n, tbl[i].pc1);
      chk($sformatf("v%0d_jump", i), 32'(bus0.ret_jump), 32'(tbl[i].jump));
      chk($sformatf("v%0d_busy", i), 32'(bus0.ret_busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_err", i), 32'(bus0.ret_err), 32'd0);
    end
    // reset while in RDPC
`ifdef TRAP_RET_CHECK_EN
    bus0.trap_jump = 1'b1;
    @(negedge clk);
    bus0.trap_jump = 1'b0;
`endif
    @(negedge clk);
    bus0.mret = 1'b1; mst = 32'h80; mepc = 32'h4444;
    repeat (2) @(negedge clk);
    #1 chk("pre_rst_addr", 32'(bus0.csr_addr), 32'h341);
    rst_n = 1'b0; bus0.mret = 1'b0;
    #1;
    chk("midrst_state", 32'(dut.state), 32'd0);
    chk("midrst_mepc", dut.mepc_r, 32'h0);
    chk("midrst_busy", 32'(bus0.ret_busy), 32'd0);
    chk("midrst_we", 32'(bus0.csr_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("postrst%0d_jump", i), 32'(bus0.ret_jump), 32'd0);
      chk($sformatf("postrst%0d_mepc", i), dut.mepc_r, 32'h0);
    end
`ifdef TRAP_RET_CHECK_EN
    @(negedge clk);
    bus0.mret = 1'b1;
    #1;
    chk("illegal_err", 32'(bus0.ret_err), 32'd1);
    chk("illegal_busy", 32'(bus0.ret_busy), 32'd0);
    chk("illegal_we", 32'(bus0.csr_we), 32'd0);
    @(negedge clk);
    bus0.mret = 1'b0;
    #1;
    chk("illegal_err_drop", 32'(bus0.ret_err), 32'd0);
    chk("illegal_state", 32'(dut.state), 32'd0);
    bus0.trap_jump = 1'b1;
    repeat (2) @(negedge clk);
    bus0.trap_jump = 1'b0;
    run_ret(32'h80, 32'h300, 32'h88, 32'h300);
    run_ret(32'h0, 32'h404, 32'h80, 32'h404);
    @(negedge clk);
    bus0.mret = 1'b1;
    #1;
    chk("third_err", 32'(bus0.ret_err), 32'd1);
    chk("third_busy", 32'(bus0.ret_busy), 32'd0);
    @(negedge clk);
    bus0.mret = 1'b0;
    #1 chk("third_we", 32'(bus0.csr_we), 32'd0);
`else
    run_ret(32'h1808, 32'h5556, 32'h1880, 32'h5554);
    @(negedge clk); #1;
    chk("after_ret_busy", 32'(bus0.ret_busy), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/trap_ret.md
Name: trap_ret

Overview:
- Trap-exit sequencer for the core; the return-side counterpart of the trap-entry FSM.
- On a decoded `mret` it performs three steps through the shared CSR port:
  - restores mstatus (MIE←MPIE, MPIE←1);
  - fetches mepc;
  - issues a PC redirect.
- Sits beside the trap-entry unit between idex and csr_reg. Its next-PC output is muxed into the PC path after the trap-entry arbitration.

Parameters:
- MEPC_ALIGN, 2: number of mepc LSBs forced to 0 on return. Use 2 for RV32I, 1 with C extension.
- DEPTH_W, 4: width of the trap nesting-depth counter. Only used when TRAP_RET_CHECK_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mret_i  in  1  decoded mret from idex; held high (pipeline stalled) until ret_jump_o
- trap_in_i  in  1  trap-entry unit active/entering; has priority over return
- trap_jump_i  in  1  trap-entry unit's jump-to-mtvec pulse (nesting count)
- csr_rdata_i  in  32  combinational read data for csr_addr_o
- csr_wdata_o  out  32  CSR write data
- csr_we_o  out  1  CSR write enable
- csr_addr_o  out  12  CSR address
- pc_n_i  in  32  next PC from idex
- pc_n_o  out  32  next PC after return arbitration
- ret_jump_o  out  1  one-cycle redirect strobe to mepc
- ret_busy_o  out  1  stall request while return is in progress
- ret_err_o  out  1  illegal-mret pulse (only with TRAP_RET_CHECK_EN, else tied 0)

Behaviour:
- Reset values:
  - state = IDLE, mepc_r = 0, depth = 0;
  - all outputs 0, except pc_n_o = pc_n_i.
- Default outputs in every state: csr_we_o = 0, csr_addr_o = 0, csr_wdata_o = 0, pc_n_o = pc_n_i, ret_jump_o = 0.
- State machine IDLE → WMST → RDPC → JMPC → IDLE. Accept condition: acc = mret_i & ~trap_in_i (& ~illegal when checking is enabled).
- IDLE:
  - if acc: go to WMST, and ret_busy_o = 1 combinationally in this same cycle;
  - if mret_i & trap_in_i: stay in IDLE, drive nothing. Trap entry wins; mret is retried after the trap handler.
- WMST:
  - csr_addr_o = mstatus (0x300), csr_we_o = 1;
  - csr_wdata_o = {rdata[31:8], 1'b1, rdata[6:4], rdata[7], rdata[2:0]}, i.e. MIE(bit3) ← MPIE(bit7), MPIE ← 1, all other bits unchanged;
  - ret_busy_o = 1; next state RDPC.
- RDPC:
  - csr_addr_o = mepc (0x341), csr_we_o = 0;
  - mepc_r ← csr_rdata_i with low MEPC_ALIGN bits cleared, registered at end of cycle;
  - ret_busy_o = 1; next state JMPC.
- JMPC:
  - pc_n_o = mepc_r, ret_jump_o = 1, ret_busy_o = 1; next state IDLE.
- Latency: WMST, RDPC and JMPC are the 1st, 2nd and 3rd cycles after acceptance. mret_i is ignored outside IDLE.
- Mid-sequence behaviour:
  - once accepted, the sequence is not abortable;
  - trap_in_i is ignored until IDLE;
  - idex must not raise new exceptions while ret_busy_o = 1 (the pipeline is stalled).
- Back-to-back: mret_i still high in the IDLE cycle after JMPC is treated as a new mret. idex must drop mret_i on ret_jump_o.
- Reset asserted mid-sequence: immediate return to IDLE. No partial CSR write persists beyond the current cycle.

Optional Feature:
- Macro: TRAP_RET_CHECK_EN.
- Defined:
  - depth counter (DEPTH_W bits) increments on trap_jump_i and decrements on JMPC;
  - saturates at all-ones; never underflows;
  - simultaneous increment and decrement leaves it unchanged.
  - mret_i & ~trap_in_i with depth == 0 is illegal: ret_err_o pulses 1 for one cycle, state stays IDLE, no CSR access, ret_busy_o = 0;
  - idex routes ret_err_o to inst_err.
- Undefined: no counter, ret_err_o = 0, every mret is accepted.

Test Plan:
- mstatus = 0x0000_0080, mepc = 0x0000_1236, mret_i held → cycle+1 writes mstatus = 0x0000_0088; cycle+3 ret_jump_o = 1 with pc_n_o = 0x0000_1234; back in IDLE at cycle+4.
- mstatus = 0x0000_1808 (MPIE = 0, MIE = 1) → written 0x0000_1880; MPP bits 12:11 preserved.
- mret_i and trap_in_i both high for 5 cycles → no CSR write, ret_busy_o = 0; after trap_in_i falls, the sequence starts next cycle.
- Reset pulsed while in RDPC → state IDLE, ret_jump_o never asserted, mepc_r = 0.
- With TRAP_RET_CHECK_EN, depth 0:
  - mret → ret_err_o single pulse, no CSR write;
  - after 2 trap_jump_i pulses, two mrets succeed and a third errors.
- MEPC_ALIGN = 1, mepc = 0x0000_2003 → pc_n_o = 0x0000_2002.
